// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and lock state shared by VGA generator and receiver
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    // Lines and pixels start with the sync pulse, so active video follows sync + back porch.
    localparam int H_ACTIVE_START = H_SYNC + H_BACK;
    localparam int V_ACTIVE_START = V_SYNC + V_BACK;

    localparam int LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        LOCK_SEARCH,
        LOCK_VERIFY,
        LOCK_LOCKED
    } lock_state_t;

endpackage

// File: rtl/vga_timing_receiver_if.sv
// rtl/vga_timing_receiver_if.sv - VGA link input and captured pixel stream bundle
interface vga_timing_receiver_if;

    logic        h_sync;
    logic        v_sync;
    logic [7:0]  red_in;
    logic [7:0]  green_in;
    logic [7:0]  blue_in;

    logic        pixel_valid;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        frame_start;
    logic        locked;
    logic        sync_err;
    logic [11:0] line_len;
    logic [10:0] frame_lines;

    modport master (
        output h_sync, v_sync, red_in, green_in, blue_in,
        input  pixel_valid, pixel_x, pixel_y, red, green, blue,
        input  frame_start, locked, sync_err, line_len, frame_lines
    );

    modport slave (
        input  h_sync, v_sync, red_in, green_in, blue_in,
        output pixel_valid, pixel_x, pixel_y, red, green, blue,
        output frame_start, locked, sync_err, line_len, frame_lines
    );

endinterface

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - registers a sync input and flags its rising edge
module vga_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic rise
);

    logic sync_q;
    logic sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= sync_in;
            sync_d <= sync_q;
        end
    end

    assign rise = sync_q & ~sync_d;

endmodule

// File: rtl/vga_timing_receiver.sv
// rtl/vga_timing_receiver.sv - measures VGA line/frame timing, locks, and emits active pixel coordinates
module vga_timing_receiver
    import vga_timing_pkg::*;
#(
    parameter int WIDTH          = H_ACTIVE,
    parameter int HEIGHT         = V_ACTIVE,
    parameter int H_TOTAL        = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL        = vga_timing_pkg::V_TOTAL,
    parameter int H_ACTIVE_START = vga_timing_pkg::H_ACTIVE_START,
    parameter int V_ACTIVE_START = vga_timing_pkg::V_ACTIVE_START,
    parameter int LOCK_FRAMES    = vga_timing_pkg::LOCK_FRAMES
) (
    input logic                  clk,
    input logic                  rst,
    vga_timing_receiver_if.slave vif
);

    localparam logic [11:0] HT = 12'(H_TOTAL);
    localparam logic [10:0] VT = 11'(V_TOTAL);
    localparam logic [11:0] HS = 12'(H_ACTIVE_START);
    localparam logic [11:0] HE = 12'(H_ACTIVE_START + WIDTH);
    localparam logic [10:0] VS = 11'(V_ACTIVE_START);
    localparam logic [10:0] VE = 11'(V_ACTIVE_START + HEIGHT);
    localparam logic [3:0]  LF = 4'(LOCK_FRAMES);

    logic        h_rise, v_rise;
    logic [7:0]  red_d, green_d, blue_d;
    logic [11:0] h_pos, h_inc, h_cur;
    logic [10:0] v_line, v_inc, v_cur;
    logic        v_pend, pend_eff, frame_end, mismatch, active, valid_nx;
    logic [9:0]  x_off, y_off;
    lock_state_t state, state_nx;
    logic [3:0]  good_cnt, good_nx;

    logic        pixel_valid_q, frame_start_q, locked_q, sync_err_q;
    logic [9:0]  pixel_x_q, pixel_y_q;
    logic [7:0]  red_q, green_q, blue_q;
    logic [11:0] line_len_q;
    logic [10:0] frame_lines_q;

    vga_sync_edge u_h_edge (.clk(clk), .rst(rst), .sync_in(vif.h_sync), .rise(h_rise));
    vga_sync_edge u_v_edge (.clk(clk), .rst(rst), .sync_in(vif.v_sync), .rise(v_rise));

    always_ff @(posedge clk) begin
        if (rst) begin
            red_d   <= '0;
            green_d <= '0;
            blue_d  <= '0;
        end else begin
            red_d   <= vif.red_in;
            green_d <= vif.green_in;
            blue_d  <= vif.blue_in;
        end
    end

    // h_cur/v_cur are the position of the sample currently in the input register.
    always_comb begin
        h_inc     = (h_pos == 12'hfff) ? h_pos : h_pos + 12'd1;
        h_cur     = h_rise ? 12'd0 : h_inc;
        v_inc     = (v_line == 11'h7ff) ? v_line : v_line + 11'd1;
        pend_eff  = v_pend | v_rise;
        frame_end = h_rise & pend_eff;
        v_cur     = h_rise ? (pend_eff ? 11'd0 : v_inc) : v_line;
        // The timeout fires once: h_pos only passes through H_TOTAL on its way to saturation.
        mismatch  = (h_rise & (h_inc != HT)) | (~h_rise & (h_inc == HT))
                  | (frame_end & (v_inc != VT));
        active    = (h_cur >= HS) && (h_cur < HE) && (v_cur >= VS) && (v_cur < VE);
        x_off     = 10'(h_cur - HS);
        y_off     = 10'(v_cur - VS);
    end

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        case (state)
            LOCK_SEARCH: begin
                if (frame_end) begin
                    state_nx = LOCK_VERIFY;
                    good_nx  = 4'd0;
                end
            end
            LOCK_VERIFY: begin
                if (mismatch) begin
                    state_nx = LOCK_SEARCH;
                end else if (frame_end) begin
                    good_nx = good_cnt + 4'd1;
                    if (good_cnt + 4'd1 == LF) begin
                        state_nx = LOCK_LOCKED;
                    end
                end
            end
            LOCK_LOCKED: begin
                if (mismatch) begin
                    state_nx = LOCK_SEARCH;
                end
            end
            default: state_nx = LOCK_SEARCH;
        endcase
        valid_nx = active && (state_nx == LOCK_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOCK_SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_pos         <= '0;
            v_line        <= '0;
            v_pend        <= 1'b0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            pixel_valid_q <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            h_pos  <= h_cur;
            v_line <= v_cur;
            v_pend <= pend_eff & ~h_rise;
            if (h_rise) begin
                line_len_q <= h_inc;
            end
            if (frame_end) begin
                frame_lines_q <= v_inc;
            end
            pixel_valid_q <= valid_nx;
            pixel_x_q     <= valid_nx ? x_off : '0;
            pixel_y_q     <= valid_nx ? y_off : '0;
            red_q         <= valid_nx ? red_d : '0;
            green_q       <= valid_nx ? green_d : '0;
            blue_q        <= valid_nx ? blue_d : '0;
            frame_start_q <= valid_nx && (x_off == 10'd0) && (y_off == 10'd0);
            locked_q      <= (state_nx == LOCK_LOCKED);
            sync_err_q    <= mismatch;
        end
    end

    assign vif.pixel_valid = pixel_valid_q;
    assign vif.pixel_x     = pixel_x_q;
    assign vif.pixel_y     = pixel_y_q;
    assign vif.red         = red_q;
    assign vif.green       = green_q;
    assign vif.blue        = blue_q;
    assign vif.frame_start = frame_start_q;
    assign vif.locked      = locked_q;
    assign vif.sync_err    = sync_err_q;
    assign vif.line_len    = line_len_q;
    assign vif.frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// tb/tb_vga_timing_receiver.sv - directed scoreboard bench for vga_timing_receiver on a reduced video mode
module tb_vga_timing_receiver;

    localparam int W   = 16;
    localparam int H   = 8;
    localparam int HT  = 24;
    localparam int VT  = 14;
    localparam int HAS = 6;
    localparam int VAS = 3;
    localparam int HSW = 2;
    localparam int VSW = 2;
    localparam int FRAME = HT * VT;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         stamp;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vga_timing_receiver_if vif();

    vga_timing_receiver #(
        .WIDTH(W), .HEIGHT(H), .H_TOTAL(HT), .V_TOTAL(VT),
        .H_ACTIVE_START(HAS), .V_ACTIVE_START(VAS), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vif(vif)
    );

    always #5 clk = ~clk;

    pix_t sbq[$];
    int total = 0;
    int bad = 0;
    int tick = 0;
    int gh = 0, gv = 0, hlen = HT, vhofs = 5;
    bit sb_on = 0, sb_chk = 0;
    int err_cnt = 0, pv_cnt = 0, fs_cnt = 0, pop_cnt = 0, bnd_cnt = 0, bnd_tick = -100;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        pix_t p;
        bit   exp_v;
        if (vif.sync_err)    err_cnt++;
        if (vif.pixel_valid) pv_cnt++;
        if (vif.frame_start) fs_cnt++;
        if (sb_chk) begin
            while (sbq.size() > 0 && sbq[0].stamp < tick - 2) void'(sbq.pop_front());
            exp_v = (sbq.size() > 0) && (sbq[0].stamp == tick - 2);
            check("sb_valid", vif.pixel_valid, exp_v);
            if (exp_v && vif.pixel_valid) begin
                p = sbq.pop_front();
                pop_cnt++;
                check("sb_pixel",
                      {vif.pixel_x, vif.pixel_y, vif.red, vif.green, vif.blue, vif.frame_start},
                      {p.x, p.y, p.r, p.g, p.b, (p.x == 10'd0 && p.y == 10'd0)});
            end else if (!vif.pixel_valid) begin
                check("rgb_idle", {vif.red, vif.green, vif.blue}, 24'd0);
            end
        end
    endtask

    // One generator clock: sync pulses lead each line/frame; v_sync may rise mid-line (vhofs>0).
    task automatic step();
        int   idx, st;
        pix_t p;
        idx = gv * HT + gh;
        st  = (vhofs == 0) ? 0 : (VT - 1) * HT + vhofs;
        vif.h_sync   = (gh < HSW);
        vif.v_sync   = (((idx - st + FRAME) % FRAME) < VSW * HT);
        vif.red_in   = tick[7:0];
        vif.green_in = tick[15:8];
        vif.blue_in  = 8'(gh * 7 + gv);
        if (gh == 0 && gv == 0) begin
            bnd_cnt++;
            bnd_tick = tick;
        end
        if (sb_on && gh >= HAS && gh < HAS + W && gv >= VAS && gv < VAS + H) begin
            p.x = 10'(gh - HAS);
            p.y = 10'(gv - VAS);
            p.r = vif.red_in;
            p.g = vif.green_in;
            p.b = vif.blue_in;
            p.stamp = tick;
            sbq.push_back(p);
        end
        @(posedge clk);
        #1;
        tick++;
        monitor();
        gh++;
        if (gh >= hlen) begin
            gh   = 0;
            hlen = HT;
            gv   = (gv + 1) % VT;
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(gh == h && gv == v) && n < 2 * FRAME) begin
            step();
            n++;
        end
        check("run_to_reached", {gh[15:0], gv[15:0]}, {h[15:0], v[15:0]});
    endtask

    // Lock must rise on the output cycle of the third frame boundary after loss of lock.
    task automatic wait_lock(input string tag);
        int n = 0;
        bnd_cnt = 0;
        pv_cnt  = 0;
        while (!vif.locked && n < 6 * FRAME) begin
            step();
            n++;
        end
        check({tag, "_locked"}, vif.locked, 1'b1);
        check({tag, "_boundaries"}, bnd_cnt, 3);
        check({tag, "_lock_latency"}, tick - bnd_tick, 2);
        check({tag, "_no_pixels_unlocked"}, pv_cnt, 0);
    endtask

    task automatic sb_frame(input string tag);
        int fs0;
        run_to(0, 0);
        fs0 = fs_cnt;
        pop_cnt = 0;
        sbq.delete();
        sb_chk = 1;
        sb_on  = 1;
        repeat (FRAME) step();
        sb_on = 0;
        repeat (3) step();
        sb_chk = 0;
        check({tag, "_pixel_count"}, pop_cnt, W * H);
        check({tag, "_frame_start_count"}, fs_cnt - fs0, 1);
        check({tag, "_queue_empty"}, sbq.size(), 0);
        check({tag, "_still_locked"}, vif.locked, 1'b1);
    endtask

    initial begin
        int e0, first_err;

        vif.h_sync = 0; vif.v_sync = 0;
        vif.red_in = 0; vif.green_in = 0; vif.blue_in = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_fs_err", {vif.pixel_valid, vif.frame_start, vif.sync_err}, 3'd0);
        check("rst_locked", vif.locked, 1'b0);
        check("rst_line_len", vif.line_len, 12'd0);
        check("rst_frame_lines", vif.frame_lines, 11'd0);
        check("rst_xy", {vif.pixel_x, vif.pixel_y}, 20'd0);
        check("rst_rgb", {vif.red, vif.green, vif.blue}, 24'd0);
        rst = 0;

        // Initial acquisition starting mid-frame, v_sync rising mid-line (pending path).
        gh = 0; gv = VT / 2; hlen = HT; vhofs = 5;
        wait_lock("lock0");
        check("lock0_line_len", vif.line_len, 12'(HT));
        check("lock0_frame_lines", vif.frame_lines, 11'(VT));

        sb_frame("sb0");

        // One short line while locked.
        e0 = err_cnt;
        run_to(0, 5);
        hlen = HT - 1;
        run_to(0, 6);
        step();
        step();
        check("short_sync_err", vif.sync_err, 1'b1);
        check("short_locked", vif.locked, 1'b0);
        check("short_valid", vif.pixel_valid, 1'b0);
        check("short_line_len", vif.line_len, 12'(HT - 1));
        wait_lock("relock_short");
        check("short_err_pulses", err_cnt - e0, 1);

        // h_sync stuck low: one timeout pulse, measurement held.
        run_to(0, 9);
        e0 = err_cnt;
        first_err = -1;
        vif.h_sync = 0; vif.v_sync = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            tick++;
            if (vif.sync_err) begin
                err_cnt++;
                if (first_err < 0) first_err = i;
            end
        end
        check("timeout_pulses", err_cnt - e0, 1);
        check("timeout_cycle", first_err, 1);
        check("timeout_line_len", vif.line_len, 12'(HT));
        check("timeout_locked", vif.locked, 1'b0);
        gh = 0; gv = VT / 2; hlen = HT;
        wait_lock("relock_timeout");

        // Switch to v_sync rising together with h_sync.
        run_to(0, 2);
        vhofs = 0;
        e0 = err_cnt;
        sb_frame("sb_coinc");
        check("coinc_frame_lines", vif.frame_lines, 11'(VT));
        check("coinc_no_err", err_cnt - e0, 0);

        // One-cycle reset in the middle of an active line.
        run_to(10, 4);
        rst = 1;
        step();
        rst = 0;
        check("midrst_valid_fs_err", {vif.pixel_valid, vif.frame_start, vif.sync_err}, 3'd0);
        check("midrst_locked", vif.locked, 1'b0);
        check("midrst_lens", {vif.line_len, vif.frame_lines}, 23'd0);
        check("midrst_xy_rgb", {vif.pixel_x, vif.pixel_y, vif.red, vif.green, vif.blue}, 44'd0);
        wait_lock("relock_rst");
        check("relock_rst_frame_lines", vif.frame_lines, 11'(VT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
